// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_sequencer_if : branch/decode/instruction-memory signals of fetch_sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
interface fetch_sequencer_if;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  branch_taken, branch_pc, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output branch_taken, branch_pc, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_sequencer : PC owner and req/ack instruction fetcher with a one-entry
//                   output buffer and in-flight branch redirect handling
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input wire clk,
  input wire reset_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_FULL    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_imem_req;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_redirect_pc;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic [31:0] w_branch_pc;

  assign w_branch_pc = bus.branch_pc & 32'hFFFF_FFFC;

  // fetch_pc is never touched while a request is outstanding, so it doubles
  // as the held request address in both FETCH and DISCARD.
  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_imem_req    <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_redirect_pc <= 32'h0;
      r_inst_valid  <= 1'b0;
      r_inst        <= 32'h0;
      r_inst_pc     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.branch_taken) r_fetch_pc <= w_branch_pc;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end

        S_FETCH: begin
          if (bus.imem_ack) begin
            if (bus.branch_taken) begin
              r_fetch_pc <= w_branch_pc;
            end else begin
              r_inst       <= bus.imem_rdata;
              r_inst_pc    <= r_fetch_pc;
              r_inst_valid <= 1'b1;
              r_fetch_pc   <= r_fetch_pc + PC_STEP;
              r_imem_req   <= 1'b0;
              r_state      <= S_FULL;
            end
          end else if (bus.branch_taken) begin
            // Request cannot be withdrawn; let it finish and drop its data.
            r_redirect_pc <= w_branch_pc;
            r_state       <= S_DISCARD;
          end
        end

        S_FULL: begin
          if (bus.branch_taken) begin
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= w_branch_pc;
            r_imem_req   <= 1'b1;
            r_state      <= S_FETCH;
          end else if (!bus.stall) begin
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b1;
            r_state      <= S_FETCH;
          end
        end

        S_DISCARD: begin
          if (bus.imem_ack) begin
            r_fetch_pc <= bus.branch_taken ? w_branch_pc : r_redirect_pc;
            r_state    <= S_FETCH;
          end else if (bus.branch_taken) begin
            r_redirect_pc <= w_branch_pc;
          end
        end

        default: begin
          r_imem_req <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// tb_fetch_sequencer : directed stimulus, variable-latency memory responder,
// and a transaction-level model compared against the DUT every cycle.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks after mem_lat wait cycles; data is address-derived unless overridden.
  int   mem_lat  = 0;
  int   w_cnt    = 0;
  logic prev_req = 1'b0;
  logic fixed_en = 1'b0;
  assign bus.imem_rdata = fixed_en ? 32'h1234_5678 : (bus.imem_addr ^ 32'hA5A5_0000);

  always @(posedge clk) begin
    #1;
    if (!bus.imem_req) begin
      w_cnt = 0;
      bus.imem_ack = 1'b0;
    end else begin
      if (!prev_req || bus.imem_ack) w_cnt = 0;
      else w_cnt = w_cnt + 1;
      bus.imem_ack = (w_cnt >= mem_lat);
    end
    prev_req = bus.imem_req;
  end

  // Model: tracks the outstanding request, whether its data is doomed, and the buffer.
  logic        m_started, m_req, m_drop, m_valid;
  logic [31:0] m_next, m_target, m_inst, m_pc, m_bp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_started = 1'b0; m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
      m_next = RST_PC; m_target = 32'h0; m_inst = 32'h0; m_pc = 32'h0;
    end else begin
      m_bp = {bus.branch_pc[31:2], 2'b00};
      if (!m_started) begin
        m_started = 1'b1;
        m_req = 1'b1;
        if (bus.branch_taken) m_next = m_bp;
      end else if (m_valid) begin
        if (bus.branch_taken) begin
          m_valid = 1'b0; m_next = m_bp; m_req = 1'b1;
        end else if (!bus.stall) begin
          m_valid = 1'b0; m_req = 1'b1;
        end
      end else if (m_req) begin
        if (bus.imem_ack) begin
          if (m_drop) begin
            m_next = bus.branch_taken ? m_bp : m_target;
            m_drop = 1'b0;
          end else if (bus.branch_taken) begin
            m_next = m_bp;
          end else begin
            m_valid = 1'b1; m_inst = bus.imem_rdata; m_pc = m_next;
            m_next = m_next + 32'd4; m_req = 1'b0;
          end
        end else if (bus.branch_taken) begin
          m_drop = 1'b1; m_target = m_bp;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("model imem_req", 32'(bus.imem_req), 32'(m_req));
      if (m_req) chk("model imem_addr", bus.imem_addr, m_next);
      chk("model inst_valid", 32'(bus.inst_valid), 32'(m_valid));
      chk("model inst", bus.inst, m_inst);
      chk("model inst_pc", bus.inst_pc, m_pc);
    end
  end

  task automatic wait_req(input int max, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      found = bus.imem_req;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no imem_req within %0d cycles", name, max);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    bus.branch_taken = 1'b0;
    bus.branch_pc    = 32'h0;
    bus.stall        = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst imem_addr", bus.imem_addr, RST_PC);
    chk("rst inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst inst", bus.inst, 32'h0);
    chk("rst inst_pc", bus.inst_pc, 32'h0);
    tick();
    reset_n = 1'b1;

    // Sequential fetch 0,4,8,C with zero-wait memory
    for (int i = 0; i < 4; i++) begin
      wait_req(4, "seq req");
      chk("seq addr", bus.imem_addr, 32'(i * 4));
      chk("seq valid low", 32'(bus.inst_valid), 32'h0);
      @(negedge clk);
      chk("seq valid", 32'(bus.inst_valid), 32'h1);
      chk("seq inst_pc", bus.inst_pc, 32'(i * 4));
      chk("seq inst", bus.inst, 32'(i * 4) ^ 32'hA5A5_0000);
    end

    // Stall hold
    wait_req(4, "stall req");
    p = bus.imem_addr;
    fixed_en = 1'b1;
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall valid", 32'(bus.inst_valid), 32'h1);
      chk("stall inst", bus.inst, 32'h1234_5678);
      chk("stall inst_pc", bus.inst_pc, 32'h0000_0010);
      chk("stall req", 32'(bus.imem_req), 32'h0);
    end
    tick();
    bus.stall = 1'b0;
    fixed_en = 1'b0;
    wait_req(4, "post-stall req");
    chk("post-stall addr", bus.imem_addr, p + 32'd4);

    // Redirect from FULL while stalled
    bus.stall = 1'b1;
    @(negedge clk);
    tick();
    bus.branch_taken = 1'b1;
    bus.branch_pc = 32'h0000_0103;
    @(negedge clk);
    chk("redir pre valid", 32'(bus.inst_valid), 32'h1);
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("redir valid", 32'(bus.inst_valid), 32'h0);
    chk("redir req", 32'(bus.imem_req), 32'h1);
    chk("redir addr", bus.imem_addr, 32'h0000_0100);
    @(negedge clk);
    chk("redir inst_pc", bus.inst_pc, 32'h0000_0100);
    mem_lat = 3;

    // In-flight redirect on a 3-cycle fetch of address 8
    tick();
    bus.branch_taken = 1'b1;
    bus.branch_pc = 32'h8;
    tick();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);
    chk("inflight addr0", bus.imem_addr, 32'h8);
    tick();
    bus.branch_taken = 1'b1;
    bus.branch_pc = 32'h40;
    @(negedge clk);
    chk("inflight addr1", bus.imem_addr, 32'h8);
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("inflight addr2", bus.imem_addr, 32'h8);
    @(negedge clk);
    chk("inflight addr3", bus.imem_addr, 32'h8);
    chk("inflight valid", 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    chk("inflight new addr", bus.imem_addr, 32'h40);
    chk("inflight dropped", 32'(bus.inst_valid), 32'h0);
    mem_lat = 6;

    // Double redirect while discarding
    tick();
    bus.branch_taken = 1'b1;
    bus.branch_pc = 32'h40;
    tick();
    bus.branch_pc = 32'h80;
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("dbl stale addr", bus.imem_addr, 32'h40);
    repeat (4) @(negedge clk);
    chk("dbl req", 32'(bus.imem_req), 32'h1);
    chk("dbl addr", bus.imem_addr, 32'h80);

    // Asynchronous reset during a pending request
    @(negedge clk);
    reset_n = 1'b0;
    mem_lat = 0;
    #1;
    chk("async req", 32'(bus.imem_req), 32'h0);
    chk("async valid", 32'(bus.inst_valid), 32'h0);
    chk("async addr", bus.imem_addr, RST_PC);
    tick();
    tick();
    reset_n = 1'b1;
    wait_req(4, "restart req");
    chk("restart addr", bus.imem_addr, RST_PC);

    // Wrap at top of address space (low bits of target ignored)
    bus.stall = 1'b1;
    @(negedge clk);
    tick();
    bus.branch_taken = 1'b1;
    bus.branch_pc = 32'hFFFF_FFFE;
    bus.stall = 1'b0;
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("wrap top addr", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap req", 32'(bus.imem_req), 32'h1);
    chk("wrap addr", bus.imem_addr, 32'h0);

    // Branch in IDLE, then branch coinciding with an ack in FETCH
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_pc = 32'h23;
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("idle br addr", bus.imem_addr, 32'h20);
    bus.branch_taken = 1'b1;
    bus.branch_pc = 32'h300;
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    chk("ackbr valid", 32'(bus.inst_valid), 32'h0);
    chk("ackbr addr", bus.imem_addr, 32'h300);
    @(negedge clk);
    chk("ackbr inst", bus.inst, 32'hA5A5_0300);
    chk("ackbr inst_pc", bus.inst_pc, 32'h300);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Clocked controller that owns the program counter and sequences instruction fetches from a variable-latency instruction memory over a req/ack handshake.
- Holds the fetched instruction in a one-entry output buffer until the decode stage consumes it.
- Handles branch redirects, including a redirect that arrives while a fetch is still in flight.
- Sits between the branch unit / decode stage and the instruction memory; it is the sequential replacement for free-running PC update logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, byte increment applied after each accepted sequential fetch.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- branch_taken  in  1  redirect request, sampled every cycle.
- branch_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- stall  in  1  decode not ready; the buffered instruction is held while this is 1.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch byte address; valid while imem_req=1.
- imem_ack  in  1  memory completion; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word from memory.
- inst_valid  out  1  output buffer holds a valid instruction.
- inst  out  32  buffered instruction.
- inst_pc  out  32  PC of the buffered instruction.

Behaviour:
- Reset (asynchronous, immediate on reset_n=0; an in-flight request is abandoned):
  - state=IDLE; imem_req=0; imem_addr=RESET_PC.
  - inst_valid=0; inst=0; inst_pc=0.
  - fetch_pc=RESET_PC; redirect_pc=0.
- Handshake rules:
  - While imem_req=1, imem_addr is held stable until the cycle imem_ack=1.
  - A transaction completes on a clock edge with imem_req=1 and imem_ack=1.
  - imem_ack with imem_req=0 is ignored.
- Buffer consumption: occurs on an edge where inst_valid=1 and stall=0.
- States:
  - IDLE: imem_req=0; unconditionally goes to FETCH next cycle. branch_taken in IDLE loads fetch_pc<=branch_pc.
  - FETCH: imem_req=1; imem_addr=fetch_pc.
    - ack && !branch_taken: inst<=imem_rdata; inst_pc<=fetch_pc; inst_valid<=1; fetch_pc<=fetch_pc+PC_STEP; go FULL.
    - ack && branch_taken: data dropped; fetch_pc<=branch_pc; stay FETCH. The new address is presented next cycle.
    - !ack && branch_taken: redirect_pc<=branch_pc; go DISCARD.
    - !ack && !branch_taken: stay FETCH.
  - FULL: imem_req=0; inst_valid=1.
    - branch_taken (priority over stall): inst_valid<=0 (flush); fetch_pc<=branch_pc; go FETCH.
    - else !stall: inst_valid<=0; go FETCH.
    - else: hold inst, inst_pc and inst_valid unchanged.
  - DISCARD: imem_req=1; imem_addr=the stale address, held.
    - A further branch_taken overwrites redirect_pc; the latest redirect wins.
    - On ack: data dropped; fetch_pc<=redirect_pc, or branch_pc if branch_taken is asserted in the same cycle; go FETCH.
- Minimum fetch-to-valid latency: 1 cycle after entering FETCH with an immediate ack. Sustained throughput is 1 instruction per 2 cycles with zero-wait memory and no stall.
- PC arithmetic: 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- A flushed instruction is never presented; inst_valid never rises for data returned from a pre-branch address.
- inst and inst_pc are unchanged while inst_valid=0, except on capture.

Test Plan:
- Reset sequence: hold reset_n=0, release; memory acks every request the same cycle with rdata=addr^32'hA5A5_0000.
  - Required: imem_addr sequence 0,4,8,C.
  - Required: inst_pc matches each address; inst_valid pulses every 2nd cycle.
- Stall hold: stall=1 for 5 cycles while FULL with inst=32'h1234_5678.
  - Required: inst, inst_pc and inst_valid stable; imem_req=0.
  - Required: the next request goes to inst_pc+4 after stall drops.
- Redirect from FULL: branch_taken=1 with branch_pc=32'h0000_0103 while FULL and stall=1.
  - Required: inst_valid=0 next cycle; next imem_addr=32'h0000_0100.
- In-flight redirect: memory latency 3 cycles on addr 8; branch to 32'h40 one cycle after req.
  - Required: imem_addr stays 8 until ack; rdata dropped (inst_valid stays 0); next imem_addr=32'h40.
- Double redirect: in DISCARD, branch to 0x40 then 0x80 before ack.
  - Required: next fetch at 0x80.
- Mid-fetch reset and wrap:
  - Drop reset_n during a pending req. Required: imem_req=0 asynchronously; restart at RESET_PC.
  - Separately branch to 32'hFFFF_FFFC. Required: next sequential imem_addr=32'h0.
